// File: rtl/risc_defs.sv
// Shared RISC definitions used by the datapath and the boot loader.
// Contents: instruction/byte widths, byte-lane constants, the loader FSM
// state encoding, and a helper that decodes the loader's busy states.
package risc_defs;

  localparam int INSTR_W         = 32;
  localparam int BYTE_W          = 8;
  localparam int BYTES_PER_INSTR = INSTR_W / BYTE_W;
  localparam int LANE_IDX_W      = 2;

  // Little-endian lane numbering: lane 0 holds bits 7:0, lane 3 holds bits 31:24.
  localparam logic [LANE_IDX_W-1:0] LANE_FIRST = 2'd0;
  localparam logic [LANE_IDX_W-1:0] LANE_LAST  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } loader_state_t;

  function automatic logic is_busy_state(input loader_state_t s);
    return (s == ST_LOAD) || (s == ST_WRITE) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/byte_assembler.sv
// Assembles a little-endian byte stream into 32-bit words.
// Ports:
//   clk, Reset   - system clock, synchronous active-high reset
//   clear        - discards any partial word and restarts at lane 0
//   byte_en      - a byte is accepted this cycle
//   byte_data    - the accepted byte
//   word_valid   - high in the cycle the 4th byte of a word is accepted
//   word_next    - the complete word including the byte being accepted;
//                  meaningful while word_valid is high
module byte_assembler
  import risc_defs::*;
(
  input  logic               clk,
  input  logic               Reset,
  input  logic               clear,
  input  logic               byte_en,
  input  logic [BYTE_W-1:0]  byte_data,
  output logic               word_valid,
  output logic [INSTR_W-1:0] word_next
);

  logic [LANE_IDX_W-1:0] lane;
  logic [INSTR_W-1:0]    shift_q;

  // Bytes enter at the top and move down, so after four bytes the first
  // one sits in bits 7:0.
  assign word_next  = {byte_data, shift_q[INSTR_W-1:BYTE_W]};
  assign word_valid = byte_en && (lane == LANE_LAST);

  always_ff @(posedge clk) begin
    if (Reset || clear) begin
      lane    <= LANE_FIRST;
      shift_q <= '0;
    end else if (byte_en) begin
      lane    <= lane + 1'b1;   // wraps 3 -> 0 at a word boundary
      shift_q <= word_next;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer. Takes a byte stream, writes whole
// instructions to imem from address 0 upward, then checks a trailing
// checksum word against the running sum and releases the core on success.
// Ports:
//   clk, Reset              - system clock, synchronous active-high reset
//   start, word_count       - begin a load of word_count instructions
//   byte_data/valid/ready   - incoming byte stream handshake
//   imem_we/addr/wdata      - instruction memory write port
//   cpu_hold                - core reset; low only after a good load
//   busy, done, cksum_err   - status
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | waiting for start, core held
// ST_LOAD  | collecting bytes of the next instruction
// ST_WRITE | one-cycle imem write, sum update, word counter advance
// ST_CHECK | collecting the checksum word
// ST_DONE  | load finished; cksum_err valid, start re-arms
module imem_loader
  import risc_defs::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               start,
  input  logic [ADDR_W:0]    word_count,
  input  logic [BYTE_W-1:0]  byte_data,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_hold,
  output logic               busy,
  output logic               done,
  output logic               cksum_err
);

  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

  loader_state_t      state, state_nxt;
  logic               cksum_err_nxt;
  logic [ADDR_W:0]    count_q;
  logic [ADDR_W:0]    word_cnt;
  logic [ADDR_W:0]    word_cnt_inc;
  logic [INSTR_W-1:0] sum;
  logic               byte_en;
  logic               start_ok;
  logic               count_bad;
  logic               asm_word_valid;
  logic [INSTR_W-1:0] asm_word;

  // byte_ready is a register, so the handshake has no combinational
  // path from byte_valid back to byte_ready.
  assign byte_en      = byte_valid && byte_ready;
  assign start_ok     = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign count_bad    = (word_count == '0) || (word_count > MAX_WORDS);
  assign word_cnt_inc = word_cnt + 1'b1;   // one spare bit, so 2^ADDR_W fits

  byte_assembler u_asm (
    .clk        (clk),
    .Reset      (Reset),
    .clear      (start_ok),
    .byte_en    (byte_en),
    .byte_data  (byte_data),
    .word_valid (asm_word_valid),
    .word_next  (asm_word)
  );

  always_comb begin
    state_nxt     = state;
    cksum_err_nxt = cksum_err;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt     = count_bad ? ST_DONE : ST_LOAD;
          cksum_err_nxt = count_bad;
        end
      end
      ST_LOAD: begin
        if (asm_word_valid) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        state_nxt = (word_cnt_inc == count_q) ? ST_CHECK : ST_LOAD;
      end
      ST_CHECK: begin
        if (asm_word_valid) begin
          state_nxt     = ST_DONE;
          cksum_err_nxt = (asm_word != sum);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state      <= ST_IDLE;
      cksum_err  <= 1'b0;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      count_q    <= '0;
      word_cnt   <= '0;
      sum        <= '0;
    end else begin
      state      <= state_nxt;
      cksum_err  <= cksum_err_nxt;
      byte_ready <= (state_nxt == ST_LOAD) || (state_nxt == ST_CHECK);
      imem_we    <= (state_nxt == ST_WRITE);
      busy       <= is_busy_state(state_nxt);
      done       <= (state_nxt == ST_DONE);
      cpu_hold   <= !((state_nxt == ST_DONE) && !cksum_err_nxt);

      if (start_ok && !count_bad) begin
        count_q  <= word_count;
        word_cnt <= '0;
        sum      <= '0;
      end

      if ((state == ST_LOAD) && asm_word_valid) begin
        imem_addr  <= word_cnt[ADDR_W-1:0];
        imem_wdata <= asm_word;
      end

      if (state == ST_WRITE) begin
        word_cnt <= word_cnt_inc;
        sum      <= sum + imem_wdata;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader. Expected memory writes are queued by the
// stimulus; a monitor pops and compares on every imem_we.
module tb_imem_loader;

  localparam int ADDR_W = 6;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk = 1'b0;
  logic              Reset;
  logic              start;
  logic [ADDR_W:0]   word_count;
  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              cksum_err;

  int n_pass  = 0;
  int n_total = 0;

  wr_t         exp_q[$];
  logic [31:0] wbuf[64];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .Reset      (Reset),
    .start      (start),
    .word_count (word_count),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .cksum_err  (cksum_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Write monitor / scoreboard
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {26'd0, imem_addr, imem_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", 64'(imem_addr), 64'(e.addr));
        check("write_data", 64'(imem_wdata), 64'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [ADDR_W:0] n);
    start      = 1'b1;
    word_count = n;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int guard;
    if (stall) begin
      int gaps;
      gaps = $urandom_range(0, 3);
      byte_valid = 1'b0;
      for (int g = 0; g < gaps; g++) tick();
    end
    byte_valid = 1'b1;
    byte_data  = b;
    guard = 0;
    while (byte_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    if (byte_ready !== 1'b1) check("byte_ready_timeout", 64'(byte_ready), 64'd1);
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit stall);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], stall);
  endtask

  task automatic wait_done(input string name);
    int guard;
    guard = 0;
    while (done !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    check({name, "_done"}, 64'(done), 64'd1);
  endtask

  // Queue the expected writes, then stream words and checksum.
  task automatic run_load(input int n, input logic [31:0] ck, input bit stall);
    pulse_start(n[ADDR_W:0]);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{addr: i[ADDR_W-1:0], data: wbuf[i]});
      send_word(wbuf[i], stall);
    end
    send_word(ck, stall);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit idle_ok;
    logic [31:0] sum64;

    Reset      = 1'b1;
    start      = 1'b0;
    word_count = '0;
    byte_data  = '0;
    byte_valid = 1'b0;
    repeat (3) tick();

    check("rst_cpu_hold",   64'(cpu_hold),   64'd1);
    check("rst_byte_ready", 64'(byte_ready), 64'd0);
    check("rst_imem_we",    64'(imem_we),    64'd0);
    check("rst_imem_addr",  64'(imem_addr),  64'd0);
    check("rst_imem_wdata", 64'(imem_wdata), 64'd0);
    check("rst_busy",       64'(busy),       64'd0);
    check("rst_done",       64'(done),       64'd0);
    check("rst_cksum_err",  64'(cksum_err),  64'd0);
    Reset = 1'b0;

    // Idle for 20 cycles with bytes offered: nothing consumed, core held.
    idle_ok    = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'hAA;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cpu_hold !== 1'b1 || byte_ready !== 1'b0 || imem_we !== 1'b0) idle_ok = 1'b0;
    end
    byte_valid = 1'b0;
    check("idle_20_cycles", 64'(idle_ok), 64'd1);

    // Two words, good checksum 0x20420014.
    wbuf[0] = 32'h2000_0013;
    wbuf[1] = 32'h0042_0001;
    pulse_start(7'd2);
    check("start_busy", 64'(busy), 64'd1);
    check("start_hold", 64'(cpu_hold), 64'd1);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{addr: i[ADDR_W-1:0], data: wbuf[i]});
      send_word(wbuf[i], 1'b0);
    end
    send_word(32'h2042_0014, 1'b0);
    tick();
    check("good2_done", 64'(done), 64'd1);
    check("good2_cksum_err", 64'(cksum_err), 64'd0);
    check("good2_cpu_hold", 64'(cpu_hold), 64'd0);
    check("good2_busy", 64'(busy), 64'd0);
    check("good2_all_written", 64'(exp_q.size()), 64'd0);

    // Same stream, bad checksum. A start pulse mid-load must be ignored.
    pulse_start(7'd2);
    check("restart_hold", 64'(cpu_hold), 64'd1);
    check("restart_busy", 64'(busy), 64'd1);
    pulse_start(7'd1);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{addr: i[ADDR_W-1:0], data: wbuf[i]});
      send_word(wbuf[i], 1'b0);
    end
    send_word(32'h0000_0000, 1'b0);
    wait_done("bad2");
    check("bad2_cksum_err", 64'(cksum_err), 64'd1);
    check("bad2_cpu_hold", 64'(cpu_hold), 64'd1);
    check("bad2_all_written", 64'(exp_q.size()), 64'd0);

    // Three words with random stalls; checksum 0xB6C7D8EA.
    wbuf[0] = 32'h1122_3344;
    wbuf[1] = 32'hA5A5_A5A5;
    wbuf[2] = 32'h0000_0001;
    run_load(3, 32'hB6C7_D8EA, 1'b1);
    wait_done("stall3");
    check("stall3_cksum_err", 64'(cksum_err), 64'd0);
    check("stall3_cpu_hold", 64'(cpu_hold), 64'd0);
    check("stall3_all_written", 64'(exp_q.size()), 64'd0);

    // Illegal counts go straight to DONE with an error.
    pulse_start(7'd0);
    check("cnt0_done", 64'(done), 64'd1);
    check("cnt0_cksum_err", 64'(cksum_err), 64'd1);
    check("cnt0_cpu_hold", 64'(cpu_hold), 64'd1);
    check("cnt0_byte_ready", 64'(byte_ready), 64'd0);
    pulse_start(7'd65);
    check("cnt65_done", 64'(done), 64'd1);
    check("cnt65_cksum_err", 64'(cksum_err), 64'd1);
    check("cnt65_busy", 64'(busy), 64'd0);
    repeat (3) tick();

    // Full memory: 64 words, last write at address 63.
    sum64 = '0;
    for (int i = 0; i < 64; i++) begin
      wbuf[i] = {i[7:0], 8'h5A, ~i[7:0], i[7:0] ^ 8'hC3};
      sum64   = sum64 + wbuf[i];
    end
    run_load(64, sum64, 1'b0);
    wait_done("full64");
    check("full64_cksum_err", 64'(cksum_err), 64'd0);
    check("full64_cpu_hold", 64'(cpu_hold), 64'd0);
    check("full64_all_written", 64'(exp_q.size()), 64'd0);

    // Reset two bytes into a load, then a fresh single-word load.
    pulse_start(7'd1);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("midrst_byte_ready", 64'(byte_ready), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_cpu_hold", 64'(cpu_hold), 64'd1);
    check("midrst_done", 64'(done), 64'd0);
    wbuf[0] = 32'hDEAD_BEEF;
    run_load(1, 32'hDEAD_BEEF, 1'b0);
    wait_done("postrst");
    check("postrst_cksum_err", 64'(cksum_err), 64'd0);
    check("postrst_cpu_hold", 64'(cpu_hold), 64'd0);
    repeat (2) tick();
    check("postrst_all_written", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory writer for the RISC processor. Accepts a little-endian byte stream over a valid/ready handshake, assembles 32-bit instructions, writes them sequentially into instruction memory from address 0, and verifies a trailing 32-bit checksum word. It holds the processor in reset (`cpu_hold`) until a load completes with a good checksum; the datapath's fetch port is the reader side of the memory this block writes.

## Interface

- `ADDR_W`, 6, instruction-memory address width (depth = 2^ADDR_W words)
- `clk`  in  1  system clock, all logic on rising edge
- `Reset`  in  1  synchronous, active-high reset
- `start`  in  1  single-cycle pulse; starts a load when in IDLE or DONE, ignored otherwise
- `word_count`  in  ADDR_W+1  number of instruction words; sampled on accepted `start`
- `byte_data`  in  8  stream byte
- `byte_valid`  in  1  `byte_data` is valid
- `byte_ready`  out  1  loader accepts a byte this cycle
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word
- `imem_addr`  out  ADDR_W  write address
- `imem_wdata`  out  32  write data
- `cpu_hold`  out  1  drive to the processor's `Reset`; high holds the core
- `busy`  out  1  high in LOAD, WRITE, CHECK
- `done`  out  1  high while in DONE
- `cksum_err`  out  1  valid while `done`; 1 = bad checksum or illegal `word_count`

## Operation

- States: IDLE, LOAD, WRITE, CHECK, DONE.
- IDLE: `byte_ready`=0. On `start`: if `word_count`==0 or >2^ADDR_W, go to DONE with `cksum_err`=1; otherwise latch count, clear word counter, byte counter and running sum, go to LOAD.
- LOAD: `byte_ready`=1. Each accepted byte (`byte_valid`&`byte_ready`) shifts into the assembly register: byte 0 → bits 7:0, byte 3 → bits 31:24. On the 4th byte, go to WRITE.
- WRITE (one cycle): `imem_we`=1, `imem_addr`=word counter, `imem_wdata`=assembled word, `byte_ready`=0. Running sum += word (mod 2^32). Word counter increments. If counter now equals latched count, go to CHECK, else LOAD.
- CHECK: `byte_ready`=1; assemble 4 bytes identically; the word is not written to memory. On 4th byte compare to running sum, register `cksum_err` = mismatch, go to DONE.
- DONE: `done`=1, `byte_ready`=0. `start` begins a new load exactly as from IDLE.
- `cpu_hold` = 1 in every state except DONE with `cksum_err`=0.
- `start` while `busy` is ignored; bytes offered while `byte_ready`=0 are not consumed.

## Timing

- Reset values: state IDLE, `byte_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_hold`=1, `busy`=0, `done`=0, `cksum_err`=0; counters and sum cleared.
- All outputs registered or decoded from state only; no combinational path from `byte_valid` to `byte_ready`.
- 4th data byte accepted at cycle t → `imem_we` high at t+1 → next byte acceptable at t+2. Full load of N words: 5N + 4 cycles minimum after start (+1 to DONE).
- `start` at t → `busy` at t+1, `cpu_hold` high at t+1 if it was low.
- 4th checksum byte at t → `done`, `cksum_err` valid and `cpu_hold` updated at t+1.
- `word_count` = 2^ADDR_W: last write to address 2^ADDR_W−1; address never wraps.
- `Reset` mid-load: returns to IDLE next cycle, partial bytes discarded, `cpu_hold`=1; memory already written is not cleared.
- Stalls (`byte_valid` low) anywhere in LOAD/CHECK: state, partial word and counters hold.

## Structure

- Shared package `risc_defs`: state encodings, `INSTR_W`=32, byte-lane constants, reused by datapath and loader.
- One sub-module: `byte_assembler` (2-bit byte counter + 32-bit shift register, `word_valid` pulse on 4th byte), instantiated once and reused for data and checksum words.
- FSM, word counter, running sum and output registers live in `imem_loader`.

## Test plan

- Reset then idle: `cpu_hold`=1, `byte_ready`=0, no `imem_we` for 20 cycles.
- `word_count`=2, bytes 13 00 00 20, 01 00 42 00, checksum 14 00 42 20 → writes 0x20000013 @0, 0x00420001 @1; `done`=1, `cksum_err`=0, `cpu_hold`=0.
- Same stream with checksum 00 00 00 00 → `cksum_err`=1, `cpu_hold` stays 1; memory still written.
- `byte_valid` toggled randomly during load of 3 words → identical writes, addresses 0..2 in order, no byte lost or duplicated.
- `word_count`=0 and `word_count`=65 (ADDR_W=6) → DONE next cycle, `cksum_err`=1, no writes.
- `Reset` after 2 bytes of word 1 → IDLE; new `start` with count 1 writes fresh word at address 0.
